sram_port_a_master: RTL and testbench

Burst access master that drives port A of the 1024 x 8 dual-port SRAM (ada/ina/ena/wea in, outa out) from a command/stream interface. It accepts one burst command at a time and converts it into consecutive single-byte SRAM accesses. Write bursts consume a byte stream; read bursts produce a byte stream with full backpressure. It is the initiator for the SRAM port protocol and replaces hand-driven port stimulus in system use.

---
 rtl/sram_port_a_master.sv | 167 ++++++++++++++++
 tb/tb_sram_port_a_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_a_master.sv
// Burst master for port A of the 1024x8 dual-port SRAM: turns one burst command
// into consecutive single-byte accesses, with a credit-limited read-return FIFO.
//
// state | meaning
// IDLE  | cmd_ready high; a read command issues its first beat on acceptance
// WRITE | one SRAM write per accepted wd byte until remaining reaches zero
// READ  | issue read beats while the return FIFO has room for them
// DRAIN | all beats issued; wait for the last byte to land in the FIFO
`timescale 1ns/1ps
module sram_port_a_master #(
    parameter int RD_DEPTH = 4
) (
    input  logic       clka,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_wr,
    input  logic [9:0] cmd_addr,
    input  logic [7:0] cmd_len,
    input  logic       wd_valid,
    output logic       wd_ready,
    input  logic [7:0] wd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [7:0] rd_data,
    output logic       done,
    output logic       busy,
    output logic [9:0] ada,
    output logic [7:0] ina,
    output logic       ena,
    output logic       wea,
    input  logic [7:0] outa
);

    localparam int PW = $clog2(RD_DEPTH);
    localparam int CW = PW + 2;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t        state;
    logic [9:0]    addr;
    logic [8:0]    remaining;
    logic          rd_p0;
    logic          rd_p1;
    logic [7:0]    fifo_mem [RD_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] occ;
    logic [CW-1:0] credit;
    logic          room;
    logic          push;
    logic          pop;
    logic          cmd_hs;
    logic          wd_hs;
    logic          issue;
    logic          issue_idle;
    logic          issue_any;

    // rd_p0/rd_p1 track beats whose data is still in the SRAM pipeline; a beat
    // may only issue if the FIFO is guaranteed a slot when its byte returns.
    assign push       = rd_p1;
    assign pop        = rd_valid & rd_ready;
    assign credit     = occ + CW'(rd_p0) + CW'(rd_p1) - CW'(pop);
    assign room       = (credit < CW'(RD_DEPTH));
    assign cmd_hs     = cmd_valid & cmd_ready;
    assign wd_ready   = (state == WRITE);
    assign wd_hs      = wd_valid & wd_ready;
    assign busy       = (state != IDLE);
    assign issue      = (state == READ) && (remaining != 9'd0) && room;
    assign issue_idle = (state == IDLE) && cmd_hs && !cmd_wr && room;
    assign issue_any  = issue | issue_idle;
    assign rd_valid   = (occ != '0);
    assign rd_data    = fifo_mem[rptr];

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= 10'd0;
            remaining <= 9'd0;
            cmd_ready <= 1'b0;
            done      <= 1'b0;
            ada       <= 10'd0;
            ina       <= 8'd0;
            ena       <= 1'b0;
            wea       <= 1'b0;
            rd_p0     <= 1'b0;
            rd_p1     <= 1'b0;
        end else begin
            done  <= 1'b0;
            ena   <= 1'b0;
            wea   <= 1'b0;
            rd_p0 <= issue_any;
            rd_p1 <= rd_p0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_hs) begin
                        cmd_ready <= 1'b0;
                        addr      <= cmd_addr;
                        remaining <= {1'b0, cmd_len} + 9'd1;
                        if (cmd_wr) begin
                            state <= WRITE;
                        end else if (issue_idle) begin
                            ena       <= 1'b1;
                            ada       <= cmd_addr;
                            addr      <= cmd_addr + 10'd1;
                            remaining <= {1'b0, cmd_len};
                            state     <= (cmd_len == 8'd0) ? DRAIN : READ;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (wd_hs) begin
                        ena       <= 1'b1;
                        wea       <= 1'b1;
                        ada       <= addr;
                        ina       <= wd_data;
                        addr      <= addr + 10'd1;
                        remaining <= remaining - 9'd1;
                        if (remaining == 9'd1) begin
                            state     <= IDLE;
                            done      <= 1'b1;
                            cmd_ready <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        ena       <= 1'b1;
                        ada       <= addr;
                        addr      <= addr + 10'd1;
                        remaining <= remaining - 9'd1;
                        if (remaining == 9'd1) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // the last beat is the only one left in flight
                    if (rd_p1 && !rd_p0) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
            for (int i = 0; i < RD_DEPTH; i++) fifo_mem[i] <= 8'h00;
        end else begin
            if (push) begin
                fifo_mem[wptr] <= outa;
                wptr           <= wptr + PW'(1);
            end
            if (pop) rptr <= rptr + PW'(1);
            occ <= occ + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_sram_port_a_master.sv
// Bench for sram_port_a_master: behavioural SRAM on port A, golden memory and
// pin/read-data scoreboards, table-driven bursts plus backpressure and reset cases.
`timescale 1ns/1ps
module tb_sram_port_a_master;
    localparam int RD_DEPTH = 4;

    logic       clka = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_wr;
    logic [9:0] cmd_addr;
    logic [7:0] cmd_len;
    logic       wd_valid, wd_ready;
    logic [7:0] wd_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic       done, busy;
    logic [9:0] ada;
    logic [7:0] ina;
    logic       ena, wea;
    logic [7:0] outa;

    sram_port_a_master #(.RD_DEPTH(RD_DEPTH)) dut (
        .clka(clka), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .busy(busy),
        .ada(ada), .ina(ina), .ena(ena), .wea(wea), .outa(outa)
    );

    always #5 clka = ~clka;

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    function automatic logic [7:0] pat(input logic [9:0] a);
        logic [9:0] t;
        t = a * 10'd7 + 10'd3;
        return t[7:0];
    endfunction

    function automatic logic [7:0] byte_of(input logic [7:0] seed, input logic [7:0] step, input int i);
        logic [7:0] ib;
        ib = 8'(i);
        return seed + step * ib;
    endfunction

    // behavioural SRAM port A: registered read, one-cycle access
    logic [7:0] sram [1024];
    bit         init_done;
    always @(posedge clka) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) sram[i] <= pat(10'(i));
            outa      <= 8'h00;
            init_done <= 1'b1;
        end else if (ena) begin
            if (wea) sram[ada] <= ina;
            outa <= sram[ada];
        end
    end

    typedef struct {
        bit         wr;
        logic [9:0] addr;
        logic [7:0] len;
        logic [7:0] seed;
        logic [7:0] step;
        int         gap;
        int         exp_beats;
        logic [9:0] exp_last;
        int         exp_span;
        int         exp_lat;
        int         exp_acc;
    } vec_t;

    vec_t        vt [9];
    logic [7:0]  gm [1024];
    logic [18:0] pinq [$];
    logic [7:0]  rdq [$];

    int         checks = 0;
    int         errors = 0;
    int         beats, rbeats, done_cnt;
    int         first_pin, last_pin, first_rd, hs_cyc;
    int         stall_end = 0;
    logic [9:0] last_ada;
    bit         cur_wr, cmd_hs_s, wd_hs_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [18:0] e;
        if (ena) begin
            beats++;
            if (beats == 1) first_pin = cyc;
            last_pin = cyc;
            last_ada = ada;
            if (pinq.size() == 0) begin
                checks++; errors++;
                $display("FAIL pin_unexpected actual ada=%0h required no access", ada);
            end else begin
                e = pinq.pop_front();
                chk("pin", {13'd0, wea, ada, (wea ? ina : 8'h00)}, {13'd0, e});
            end
        end
        if (rd_valid && rd_ready) begin
            rbeats++;
            if (rbeats == 1) first_rd = cyc;
            if (rdq.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected actual=%0h required no byte", rd_data);
            end else begin
                chk("rd_data", 32'(rd_data), 32'(rdq.pop_front()));
            end
        end
        if (done) begin
            done_cnt++;
            chk("done_timing", {30'd0, pinq.size() == 0, (cur_wr ? (ena && wea) : !ena)}, 32'h3);
        end
    endtask

    // one clock: sample at negedge, return at posedge+1 to drive
    task automatic tick();
        @(negedge clka);
        cmd_hs_s = cmd_valid && cmd_ready;
        wd_hs_s  = wd_valid && wd_ready;
        if (cmd_hs_s) hs_cyc = cyc;
        if (!rst) monitor();
        @(posedge clka);
        #1;
        rd_ready = (cyc >= stall_end);
    endtask

    task automatic send_cmd(input bit wr, input logic [9:0] addr, input logic [7:0] len,
                            input logic [7:0] seed, input logic [7:0] step);
        int t;
        logic [9:0] a;
        cur_wr = wr; beats = 0; rbeats = 0; done_cnt = 0;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 10'(i);
            if (wr) pinq.push_back({1'b1, a, byte_of(seed, step, i)});
            else begin
                pinq.push_back({1'b0, a, 8'h00});
                rdq.push_back(gm[a]);
            end
        end
        cmd_wr = wr; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
        t = 0; cmd_hs_s = 1'b0;
        while (!cmd_hs_s && t < 50) begin tick(); t++; end
        cmd_valid = 1'b0;
        if (!cmd_hs_s) begin
            checks++; errors++;
            $display("FAIL cmd_accept actual=timeout required=handshake");
        end
    endtask

    task automatic drive_write(input logic [9:0] addr, input int n, input logic [7:0] seed,
                               input logic [7:0] step, input int gap);
        int i = 0;
        int k = 0;
        while (i < n && k < 2000) begin
            wd_valid = ((k % (gap + 1)) == 0);
            wd_data  = byte_of(seed, step, i);
            tick();
            if (wd_hs_s) begin
                gm[addr + 10'(i)] = byte_of(seed, step, i);
                i++;
            end
            k++;
        end
        wd_valid = 1'b0;
        if (i < n) begin
            checks++; errors++;
            $display("FAIL wd_accept actual=%0d required=%0d", i, n);
        end
    endtask

    task automatic finish_cmd(input int exp_beats, input logic [9:0] exp_last, input int exp_span,
                              input int exp_lat, input int exp_acc);
        int t = 0;
        while (done_cnt == 0 && t < 2000) begin tick(); t++; end
        t = 0;
        while (rdq.size() != 0 && t < 2000) begin tick(); t++; end
        repeat (3) tick();
        chk("done_count", done_cnt, 1);
        chk("beats", beats, exp_beats);
        chk("last_ada", 32'(last_ada), 32'(exp_last));
        chk("left_over", 32'(pinq.size() + rdq.size()), 0);
        if (exp_span >= 0) chk("span", last_pin - first_pin, exp_span);
        if (exp_lat >= 0)  chk("rd_latency", first_rd - first_pin, exp_lat);
        if (exp_acc >= 0)  chk("cmd_to_pin", first_pin - hs_cyc, exp_acc);
        chk("idle_flags", {29'd0, busy, cmd_ready, rd_valid}, 32'b010);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 10'h01F, 8'd3,   8'hAA, 8'h01, 0, 4,   10'h022, 3,   -1, -1};
        vt[1] = '{1'b0, 10'h01F, 8'd3,   8'h00, 8'h00, 0, 4,   10'h022, 3,    2,  1};
        vt[2] = '{1'b1, 10'h3FE, 8'd3,   8'h11, 8'h11, 0, 4,   10'h001, 3,   -1, -1};
        vt[3] = '{1'b0, 10'h3FE, 8'd3,   8'h00, 8'h00, 0, 4,   10'h001, 3,    2,  1};
        vt[4] = '{1'b1, 10'h140, 8'd2,   8'hC0, 8'h03, 1, 3,   10'h142, 4,   -1, -1};
        vt[5] = '{1'b0, 10'h140, 8'd2,   8'h00, 8'h00, 0, 3,   10'h142, 2,    2,  1};
        vt[6] = '{1'b1, 10'h200, 8'd0,   8'h5A, 8'h00, 0, 1,   10'h200, 0,   -1, -1};
        vt[7] = '{1'b0, 10'h200, 8'd0,   8'h00, 8'h00, 0, 1,   10'h200, 0,    2,  1};
        vt[8] = '{1'b0, 10'h100, 8'd255, 8'h00, 8'h00, 0, 256, 10'h1FF, 255,  2,  1};

        for (int i = 0; i < 1024; i++) gm[i] = pat(10'(i));
        beats = 0; rbeats = 0; done_cnt = 0;
        first_pin = 0; last_pin = 0; first_rd = 0; hs_cyc = 0; last_ada = 10'd0;
        cur_wr = 1'b0; cmd_hs_s = 1'b0; wd_hs_s = 1'b0;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 10'd0; cmd_len = 8'd0;
        wd_valid = 1'b0; wd_data = 8'd0; rd_ready = 1'b1;

        repeat (3) tick();
        chk("rst_flags", {25'd0, cmd_ready, wd_ready, rd_valid, done, busy, ena, wea}, 0);
        chk("rst_ada", 32'(ada), 0);
        chk("rst_ina", 32'(ina), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        rst = 1'b0;
        repeat (2) tick();
        chk("post_rst", {30'd0, cmd_ready, busy}, 32'b10);

        for (int v = 0; v < 9; v++) begin
            send_cmd(vt[v].wr, vt[v].addr, vt[v].len, vt[v].seed, vt[v].step);
            if (vt[v].wr) drive_write(vt[v].addr, int'(vt[v].len) + 1, vt[v].seed, vt[v].step, vt[v].gap);
            finish_cmd(vt[v].exp_beats, vt[v].exp_last, vt[v].exp_span, vt[v].exp_lat, vt[v].exp_acc);
        end

        // backpressure: consumer stalls while a 16-beat read is outstanding
        send_cmd(1'b1, 10'h080, 8'd15, 8'h10, 8'h05);
        drive_write(10'h080, 16, 8'h10, 8'h05, 0);
        finish_cmd(16, 10'h08F, 15, -1, -1);
        stall_end = cyc + 25;
        rd_ready  = 1'b0;
        send_cmd(1'b0, 10'h080, 8'd15, 8'h00, 8'h00);
        repeat (20) tick();
        chk("bp_issued", beats, RD_DEPTH);
        chk("bp_ena_idle", 32'(ena), 0);
        chk("bp_no_pop", rbeats, 0);
        chk("bp_rd_valid", 32'(rd_valid), 1);
        finish_cmd(16, 10'h08F, -1, -1, 1);

        // reset in the middle of a 16-beat write, after 5 beats
        send_cmd(1'b1, 10'h300, 8'd15, 8'h70, 8'h01);
        drive_write(10'h300, 5, 8'h70, 8'h01, 0);
        repeat (2) tick();
        chk("rst_pre_beats", beats, 5);
        rst = 1'b1;
        #1;
        chk("rst_mid_flags", {25'd0, cmd_ready, wd_ready, rd_valid, done, busy, ena, wea}, 0);
        chk("rst_mid_ada", 32'(ada), 0);
        chk("rst_mid_ina", 32'(ina), 0);
        pinq.delete();
        rdq.delete();
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("rst_no_done", done_cnt, 0);
        chk("rst_after_idle", {30'd0, busy, cmd_ready}, 32'b01);
        send_cmd(1'b0, 10'h302, 8'd0, 8'h00, 8'h00);
        finish_cmd(1, 10'h302, 0, 2, 1);
        send_cmd(1'b0, 10'h305, 8'd0, 8'h00, 8'h00);
        finish_cmd(1, 10'h305, 0, 2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
